// File: rtl/icu_fill_sequencer.sv
`timescale 1ns/1ps
// Icache line-fill sequencer: fetches a four-word line from the bus interface, writes it into
// the icache RAM as half-doubleword writes, and shares the RAM port with fetch-unit reads.
module icu_fill_sequencer #(
    parameter int IC_MSB     = 13,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              test_mode,
    input  logic              fill_req,
    input  logic [27:0]       fill_addr,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_err,
    output logic              biu_req,
    output logic [27:0]       biu_addr,
    input  logic              biu_gnt,
    input  logic [31:0]       biu_data,
    input  logic              biu_data_vld,
    input  logic              biu_err,
    input  logic              ifu_rd,
    input  logic [IC_MSB-3:0] ifu_addr,
    output logic              ifu_stall,
    output logic [IC_MSB-3:0] icu_addr,
    output logic [31:0]       icu_din,
    output logic [1:0]        icu_ram_we,
    output logic              icu_enable
);

    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CMPL  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [27:0]         r_line;
    logic [1:0]          r_cnt;
    logic                w_fill_accept;
    logic                w_wr_accept;
    logic                w_last;

    logic                r_biu_req;
    logic                r_fill_busy;
    logic                r_fill_done;
    logic                r_fill_err;
    logic [IC_MSB-3:0]   r_icu_addr;
    logic [31:0]         r_icu_din;
    logic [1:0]          r_icu_we;
    logic                r_icu_en;

    logic                w_biu_req_nxt;
    logic                w_fill_busy_nxt;
    logic                w_fill_done_nxt;
    logic                w_fill_err_nxt;
    logic [IC_MSB-3:0]   w_icu_addr_nxt;
    logic [31:0]         w_icu_din_nxt;
    logic [1:0]          w_icu_we_nxt;
    logic                w_icu_en_nxt;

    assign w_fill_accept = (r_state == ST_IDLE) && fill_req && !test_mode;
    // An error beat never counts as data, even if vld is also high.
    assign w_wr_accept   = (r_state == ST_DATA) && biu_data_vld && !biu_err;
    assign w_last        = w_wr_accept && (r_cnt == LAST_WORD);

    assign ifu_stall  = w_wr_accept | test_mode;
    assign biu_req    = r_biu_req;
    assign biu_addr   = r_line;
    assign fill_busy  = r_fill_busy;
    assign fill_done  = r_fill_done;
    assign fill_err   = r_fill_err;
    assign icu_addr   = r_icu_addr;
    assign icu_din    = r_icu_din;
    assign icu_ram_we = r_icu_we;
    assign icu_enable = r_icu_en;

    // Fill FSM state register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fill_accept) w_state_nxt = ST_REQ;
                else               w_state_nxt = ST_IDLE;
            end
            ST_REQ: begin
                if (biu_gnt) w_state_nxt = ST_DATA;
                else         w_state_nxt = ST_REQ;
            end
            ST_DATA: begin
                if (biu_err)     w_state_nxt = ST_ABORT;
                else if (w_last) w_state_nxt = ST_CMPL;
                else             w_state_nxt = ST_DATA;
            end
            ST_CMPL:  w_state_nxt = ST_IDLE;
            ST_ABORT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Latched line address and word counter.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_line <= 28'h0000000;
            r_cnt  <= 2'd0;
        end else begin
            if (w_fill_accept) r_line <= fill_addr;
            else               r_line <= r_line;

            if ((r_state == ST_REQ) && biu_gnt) r_cnt <= 2'd0;
            else if (w_wr_accept)               r_cnt <= r_cnt + 2'd1;
            else                                r_cnt <= r_cnt;
        end
    end

    // Output decode: next values of every registered output, fill write wins the RAM port.
    always_comb begin
        w_biu_req_nxt   = (w_state_nxt == ST_REQ);
        w_fill_busy_nxt = (w_state_nxt != ST_IDLE);
        w_fill_done_nxt = (w_state_nxt == ST_CMPL);
        w_fill_err_nxt  = (w_state_nxt == ST_ABORT);
        w_icu_addr_nxt  = r_icu_addr;
        w_icu_din_nxt   = r_icu_din;
        w_icu_we_nxt    = 2'b00;
        w_icu_en_nxt    = 1'b1;
        if (test_mode) begin
            w_icu_we_nxt = 2'b00;
            w_icu_en_nxt = 1'b1;
        end else if (w_wr_accept) begin
            w_icu_addr_nxt = {r_line[IC_MSB-4:0], r_cnt[1]};
            w_icu_din_nxt  = biu_data;
            w_icu_we_nxt   = r_cnt[0] ? 2'b01 : 2'b10;
            w_icu_en_nxt   = 1'b0;
        end else if (ifu_rd) begin
            w_icu_addr_nxt = ifu_addr;
            w_icu_we_nxt   = 2'b00;
            w_icu_en_nxt   = 1'b0;
        end else begin
            w_icu_we_nxt = 2'b00;
            w_icu_en_nxt = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_biu_req   <= 1'b0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_err  <= 1'b0;
            r_icu_addr  <= {(IC_MSB-2){1'b0}};
            r_icu_din   <= 32'h00000000;
            r_icu_we    <= 2'b00;
            r_icu_en    <= 1'b1;
        end else begin
            r_biu_req   <= w_biu_req_nxt;
            r_fill_busy <= w_fill_busy_nxt;
            r_fill_done <= w_fill_done_nxt;
            r_fill_err  <= w_fill_err_nxt;
            r_icu_addr  <= w_icu_addr_nxt;
            r_icu_din   <= w_icu_din_nxt;
            r_icu_we    <= w_icu_we_nxt;
            r_icu_en    <= w_icu_en_nxt;
        end
    end

endmodule

// File: doc/icu_fill_sequencer.md
Name: icu_fill_sequencer

Overview:
- Instruction-cache line-fill and port-arbitration stage, directly upstream of the icache data RAM shell.
- Accepts a line-fill request, fetches a 16-byte line as four 32-bit words from the bus interface, and sequences them into the RAM as half-doubleword writes.
- Muxes fetch-unit read addresses onto the same RAM port when no write is pending.
- Drives icu_addr, icu_din, icu_ram_we and the active-low RAM enable of the RAM shell.

Parameters:
- IC_MSB, 13, MSB of the RAM byte address. Doubleword index is [IC_MSB:3], line index is [IC_MSB:4].
- LINE_WORDS, 4, 32-bit words per line. Fixed at 4; the word counter is 2 bits.

Ports:
- clk  in  1  core clock, rising edge.
- reset_l  in  1  asynchronous active-low reset.
- test_mode  in  1  BIST owns the RAM; block is quiesced.
- fill_req  in  1  single-cycle fill request; honoured only when fill_busy=0.
- fill_addr  in  28  line address [31:4] to fill.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse: line completely written.
- fill_err  out  1  one-cycle pulse: fill aborted on bus error.
- biu_req  out  1  bus read request; held until biu_gnt.
- biu_addr  out  28  line address [31:4] presented with biu_req.
- biu_gnt  in  1  bus accepts request.
- biu_data  in  32  returned word; critical word not supported, order is word 0..3.
- biu_data_vld  in  1  biu_data valid this cycle.
- biu_err  in  1  bus error; terminates the fill.
- ifu_rd  in  1  fetch read request.
- ifu_addr  in  IC_MSB-2  fetch doubleword index [IC_MSB:3].
- ifu_stall  out  1  ifu_rd not accepted this cycle (combinational).
- icu_addr  out  IC_MSB-2  RAM doubleword index, registered.
- icu_din  out  32  RAM write data, registered.
- icu_ram_we  out  2  RAM write enables. [1] = bytes 0-3 of the doubleword, [0] = bytes 4-7. Registered.
- icu_enable  out  1  RAM enable, active-low (0 = access, 1 = power-down). Registered.

Behaviour:
- Reset (async, reset_l=0): state IDLE, word count 0, and all outputs at their reset values:
  - biu_req=0, biu_addr=0, fill_busy=0, fill_done=0, fill_err=0.
  - icu_addr=0, icu_din=0, icu_ram_we=2'b00, icu_enable=1.
  - ifu_stall follows its equation.
- Reset mid-fill abandons the line silently. No fill_err pulse.
- States:
  - IDLE:
    - fill_req=1 and test_mode=0 -> REQ. Latch fill_addr.
    - fill_req while test_mode=1 is dropped.
  - REQ: biu_req=1, biu_addr=latched line. biu_gnt=1 -> DATA, count=0.
  - DATA: biu_data_vld=1 writes word[count] and increments count.
    - count==3 with vld -> CMPL.
    - biu_err=1 -> ABORT. Takes precedence over a simultaneous vld; that word is not written.
  - CMPL: fill_done=1 for one cycle -> IDLE.
  - ABORT: fill_err=1 for one cycle -> IDLE. Words already written remain; line validity is owned by the tag logic.
- fill_busy=1 in REQ, DATA, CMPL and ABORT.
- fill_req while fill_busy=1 is ignored.
- biu_data_vld and biu_err are ignored outside DATA. Extra words after the 4th are dropped.
- Write mapping for word w (0..3), one cycle after acceptance:
  - icu_addr = {line[IC_MSB:4], w[1]}
  - icu_din = biu_data
  - icu_ram_we = w[0] ? 2'b01 : 2'b10
  - icu_enable = 0
- Read path: when no write is issued this cycle and ifu_rd=1, the next cycle drives icu_addr=ifu_addr, icu_ram_we=00, icu_enable=0.
- Idle cycles (no write, no read): icu_ram_we=00, icu_enable=1, icu_addr holds its last value.
- Arbitration: ifu_stall = (state==DATA & biu_data_vld & ~biu_err) | test_mode. The fill write wins the conflict; the stalled read is retried by the fetch unit.
- test_mode=1 during a fill:
  - icu_ram_we is forced to 00 and icu_enable to 1 from the next cycle.
  - The FSM continues; writes accepted under test_mode are lost.
- Latency: fill_req to biu_req is 1 cycle. Last word accepted to fill_done is 1 cycle, coincident with the final RAM write.

Test Plan:
- Basic fill:
  - Stimulus: fill_req with fill_addr=28'h0000123, biu_gnt after 2 cycles, four words 11111111..44444444 on consecutive cycles.
  - Required response: writes (addr 0x246, we 10, 11111111), (0x246, 01, 22222222), (0x247, 10, 33333333), (0x247, 01, 44444444). fill_done pulses once, with the last write.
- Gapped data:
  - Stimulus: vld on alternate cycles.
  - Required response: the same four writes, each one cycle after its vld. fill_busy stays 1 throughout.
- Bus error:
  - Stimulus: biu_err together with the word-2 vld.
  - Required response: only words 0 and 1 written. fill_err pulses, fill_done never asserts, back in IDLE next cycle.
- Read/write conflict:
  - Stimulus: ifu_rd=1 with ifu_addr=0x010 in the same cycle as a data vld.
  - Required response: ifu_stall=1 and a write is issued.
  - Stimulus: ifu_rd=1 next cycle with no vld.
  - Required response: ifu_stall=0, then icu_addr=0x010, we=00, icu_enable=0.
- Reset mid-fill:
  - Stimulus: reset_l=0 after 2 words.
  - Required response: all outputs at reset values immediately, no fill_done or fill_err.
  - Stimulus: a new fill after reset.
  - Required response: starts cleanly at word 0.
- test_mode:
  - Stimulus: fill_req while test_mode=1.
  - Required response: no biu_req, ifu_stall=1, icu_enable=1, icu_ram_we=00.
